// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, MEM-stage and byte-wide RAM signals around mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              flush_i;
  logic              if_ready_o;
  logic [31:0]       if_data_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_ready_o;
  logic [31:0]       mem_rdata_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;
  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_ready_o, if_data_o, mem_ready_o, mem_rdata_o,
    output ram_addr_o, ram_we_o, ram_dout_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_ready_o, if_data_o, mem_ready_o, mem_rdata_o,
    input  ram_addr_o, ram_we_o, ram_dout_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising each access into byte cycles and reassembling little-endian words.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter bit FAIR   = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              grant_mem;
  logic [2:0]        mem_n;
  logic [ADDR_W-1:0] cur_addr;

  assign mem_n = (bus.mem_size_i == 2'd0) ? 3'd1 :
                 (bus.mem_size_i == 2'd1) ? 3'd2 : 3'd4;

  // On a tie, the fair policy hands the port to IF only right after a MEM grant.
  assign grant_mem = bus.mem_req_i &&
                     (!bus.if_req_i || !FAIR || (last_grant_q == OWN_IF));

  assign cur_addr = base_q + {{(ADDR_W-3){1'b0}}, k_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req_i || bus.mem_req_i) begin
          k_d          = 3'd0;
          rbuf_d       = 32'h0;
          owner_d      = grant_mem;
          last_grant_d = grant_mem;
          if (grant_mem) begin
            base_d  = bus.mem_addr_i;
            n_d     = mem_n;
            wdata_d = bus.mem_wdata_i;
            state_d = bus.mem_we_i ? S_WR : S_RD;
          end else begin
            base_d  = bus.if_addr_i;
            n_d     = 3'd4;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (bus.flush_i && (owner_q == OWN_IF)) begin
          state_d = S_IDLE;
        end else begin
          // RAM data lags its address by one cycle, so cycle k returns byte k-1.
          for (int b = 0; b < 4; b++) begin
            if (k_q == 3'(b + 1)) rbuf_d[8*b +: 8] = bus.ram_din_i;
          end
          if (k_q == n_q) begin
            state_d = S_DONE;
            if (owner_q == OWN_IF) if_data_d = rbuf_d;
            else                   mem_rdata_d = rbuf_d;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      S_WR: begin
        if (k_q == n_q - 3'd1) state_d = S_DONE;
        else                   k_d = k_q + 3'd1;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_dout = 8'h0;
    case (state_q)
      S_RD: if (k_q < n_q) ram_addr = cur_addr;
      S_WR: begin
        ram_we   = 1'b1;
        ram_addr = cur_addr;
        ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_dout_o  = ram_dout;
  assign bus.if_ready_o  = (state_q == S_DONE) && (owner_q == OWN_IF);
  assign bus.mem_ready_o = (state_q == S_DONE) && (owner_q == OWN_MEM);
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.busy_o      = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      n_q          <= 3'd0;
      k_q          <= 3'd0;
      base_q       <= '0;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      wdata_q      <= 32'h0;
      rbuf_q       <= 32'h0;
      if_data_q    <= 32'h0;
      mem_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a byte-addressed shadow memory and per-size latency rules.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32)) s_bus ();

  mem_arbiter #(.ADDR_W(32), .FAIR(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  mem_arbiter #(.ADDR_W(32), .FAIR(1'b0)) dut_strict (
    .clk(clk), .rst(rst), .bus(s_bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // RAM behind the fair instance; reads return the byte one cycle after its address.
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    bus.ram_din_i <= ram_rd(bus.ram_addr_o);
    if (bus.ram_we_o) ram[bus.ram_addr_o] = bus.ram_dout_o;
  end

  // Reference model: what the RAM ought to hold, and what each read should return.
  function automatic logic [7:0] sh_rd(logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  function automatic int nbytes(logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr, int n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(sh_rd(addr + 32'(i))) << (8 * i));
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wdata);
    for (int i = 0; i < n; i++) shadow[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr]    = b;
    shadow[addr] = b;
  endtask

  logic [31:0] exp_if_data   = 32'h0;
  logic [31:0] exp_mem_rdata = 32'h0;

  // Per-cycle trace of the RAM port, cycle 1 = first cycle after the granting edge.
  logic [31:0] tr_addr [$];
  bit          tr_we   [$];
  logic [7:0]  tr_dout [$];

  task automatic txn(input bit is_if, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output logic [31:0] data, output bit other_rdy);
    bit done = 1'b0;
    lat = -1; data = 32'h0; other_rdy = 1'b0;
    tr_addr.delete(); tr_we.delete(); tr_dout.delete();
    @(negedge clk);
    if (is_if) begin
      bus.if_req_i = 1'b1; bus.if_addr_i = addr;
    end else begin
      bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_size_i = size;
      bus.mem_addr_i = addr; bus.mem_wdata_i = wdata;
    end
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      tr_addr.push_back(bus.ram_addr_o);
      tr_we.push_back(bus.ram_we_o);
      tr_dout.push_back(bus.ram_dout_o);
      if (is_if ? bus.mem_ready_o : bus.if_ready_o) other_rdy = 1'b1;
      if (is_if ? bus.if_ready_o : bus.mem_ready_o) begin
        done = 1'b1;
        lat  = c;
        data = is_if ? bus.if_data_o : bus.mem_rdata_o;
      end
    end
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o} !== 41'h0) begin
      n_fail++; $display("FAIL reset_ram_port: got addr=%h we=%b dout=%h, need all 0",
                         bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o);
    end
    n_tests++;
    if ({bus.if_ready_o, bus.mem_ready_o, bus.busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got if_rdy/mem_rdy/busy=%b, need 000",
                         {bus.if_ready_o, bus.mem_ready_o, bus.busy_o});
    end
    n_tests++;
    if ({bus.if_data_o, bus.mem_rdata_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got if_data=%h mem_rdata=%h, need 0",
                         bus.if_data_o, bus.mem_rdata_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b, need 0", bus.busy_o);
    end
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] d; bit oth; int we_cnt = 0;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    txn(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat, d, oth);
    n_tests++;
    if (lat != 6) begin n_fail++; $display("FAIL fetch_latency: got %0d, need 6", lat); end
    n_tests++;
    if (d !== 32'h00100513) begin n_fail++; $display("FAIL fetch_data: got %h, need 00100513", d); end
    n_tests++;
    if (oth) begin n_fail++; $display("FAIL fetch_mem_ready: mem_ready_o pulsed during fetch"); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tr_addr[i] !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL fetch_addr[%0d]: got %h, need %h", i, tr_addr[i], 32'h100 + 32'(i));
      end
    end
    n_tests++;
    if (tr_addr[4] !== 32'h0) begin n_fail++; $display("FAIL fetch_addr_last: got %h, need 0", tr_addr[4]); end
    foreach (tr_we[i]) if (tr_we[i]) we_cnt++;
    n_tests++;
    if (we_cnt != 0) begin n_fail++; $display("FAIL fetch_we: ram_we_o high %0d cycles, need 0", we_cnt); end
    exp_if_data = 32'h00100513;
  endtask

  task automatic test_store();
    int lat; logic [31:0] d; bit oth;
    logic [31:0] w = 32'hDEADBEEF;
    txn(1'b0, 1'b1, 2'd2, 32'h200, w, lat, d, oth);
    model_write(32'h200, 4, w);
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL sw_latency: got %0d, need 5", lat); end
    n_tests++;
    if (d !== exp_mem_rdata) begin n_fail++; $display("FAIL sw_rdata_hold: got %h, need %h", d, exp_mem_rdata); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tr_we[i] !== 1'b1 || tr_addr[i] !== 32'h200 + 32'(i) || tr_dout[i] !== w[8*i +: 8]) begin
        n_fail++; $display("FAIL sw_cycle[%0d]: got we=%b addr=%h dout=%h, need we=1 addr=%h dout=%h",
                           i, tr_we[i], tr_addr[i], tr_dout[i], 32'h200 + 32'(i), w[8*i +: 8]);
      end
    end
    n_tests++;
    if (tr_we[4] !== 1'b0) begin n_fail++; $display("FAIL sw_we_in_done: ram_we_o=%b, need 0", tr_we[4]); end
    txn(1'b0, 1'b1, 2'd0, 32'h208, 32'h12345677, lat, d, oth);
    model_write(32'h208, 1, 32'h12345677);
    n_tests++;
    if (lat != 2 || tr_dout[0] !== 8'h77 || tr_addr[0] !== 32'h208) begin
      n_fail++; $display("FAIL sb: got lat=%0d addr=%h dout=%h, need lat=2 addr=00000208 dout=77",
                         lat, tr_addr[0], tr_dout[0]);
    end
  endtask

  task automatic test_load();
    int lat; logic [31:0] d; bit oth;
    poke(32'h301, 8'h34); poke(32'h302, 8'hF2); poke(32'h310, 8'h80);
    txn(1'b0, 1'b0, 2'd1, 32'h301, 32'h0, lat, d, oth);
    n_tests++;
    if (lat != 4 || d !== 32'h0000F234) begin
      n_fail++; $display("FAIL lh: got lat=%0d data=%h, need lat=4 data=0000f234", lat, d);
    end
    txn(1'b0, 1'b0, 2'd0, 32'h310, 32'h0, lat, d, oth);
    n_tests++;
    if (lat != 3 || d !== 32'h00000080) begin
      n_fail++; $display("FAIL lb: got lat=%0d data=%h, need lat=3 data=00000080", lat, d);
    end
    txn(1'b0, 1'b0, 2'd3, 32'h200, 32'h0, lat, d, oth);
    n_tests++;
    if (lat != 6 || d !== model_read(32'h200, 4)) begin
      n_fail++; $display("FAIL lw_after_sw: got lat=%0d data=%h, need lat=6 data=%h", lat, d, model_read(32'h200, 4));
    end
    txn(1'b0, 1'b0, 2'd0, 32'h208, 32'h0, lat, d, oth);
    n_tests++;
    if (d !== 32'h00000077) begin n_fail++; $display("FAIL lb_after_sb: got %h, need 00000077", d); end
    exp_mem_rdata = 32'h00000077;
  endtask

  task automatic test_flush();
    int lat; logic [31:0] d; bit oth; int rdy_cnt = 0;
    poke(32'h500, 8'hAA); poke(32'h501, 8'hBB); poke(32'h502, 8'hCC); poke(32'h503, 8'hDD);
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
    repeat (3) @(negedge clk);
    bus.flush_i = 1'b1; bus.if_req_i = 1'b0;
    @(negedge clk);
    bus.flush_i = 1'b0;
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.ram_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_to_idle: got busy=%b addr=%h, need busy=0 addr=0", bus.busy_o, bus.ram_addr_o);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.if_ready_o) rdy_cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (rdy_cnt != 0) begin n_fail++; $display("FAIL flush_no_ready: %0d if_ready_o pulses, need 0", rdy_cnt); end
    n_tests++;
    if (bus.if_data_o !== exp_if_data) begin
      n_fail++; $display("FAIL flush_data_hold: got %h, need %h", bus.if_data_o, exp_if_data);
    end
    poke(32'h400, 8'h93); poke(32'h401, 8'h00); poke(32'h402, 8'h10); poke(32'h403, 8'h00);
    txn(1'b1, 1'b0, 2'd2, 32'h400, 32'h0, lat, d, oth);
    n_tests++;
    if (lat != 6 || d !== 32'h00100093) begin
      n_fail++; $display("FAIL fetch_after_flush: got lat=%0d data=%h, need lat=6 data=00100093", lat, d);
    end
    exp_if_data = 32'h00100093;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d; bit oth;
    logic [31:0] a = 32'hFFFFFFFE;
    txn(1'b0, 1'b1, 2'd2, a, 32'h44332211, lat, d, oth);
    model_write(a, 4, 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tr_addr[i] !== a + 32'(i)) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %h, need %h", i, tr_addr[i], a + 32'(i));
      end
    end
    txn(1'b0, 1'b0, 2'd2, a, 32'h0, lat, d, oth);
    n_tests++;
    if (d !== 32'h44332211) begin n_fail++; $display("FAIL wrap_lw: got %h, need 44332211", d); end
    txn(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, lat, d, oth);
    n_tests++;
    if (d !== 32'h00000033) begin n_fail++; $display("FAIL wrap_lb0: got %h, need 00000033", d); end
    exp_mem_rdata = 32'h00000033;
  endtask

  task automatic test_reset_mid_write();
    int rdy_cnt = 0;
    @(negedge clk);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_size_i = 2'd2;
    bus.mem_addr_i = 32'h600; bus.mem_wdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.ram_we_o !== 1'b1 || bus.ram_addr_o !== 32'h601) begin
      n_fail++; $display("FAIL wr_k1: got we=%b addr=%h, need we=1 addr=00000601", bus.ram_we_o, bus.ram_addr_o);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.ram_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ram_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_abort: got we=%b busy=%b addr=%h, need 0/0/0",
                         bus.ram_we_o, bus.busy_o, bus.ram_addr_o);
    end
    bus.mem_req_i = 1'b0;
    shadow[32'h600] = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.if_ready_o || bus.mem_ready_o) rdy_cnt++;
    end
    n_tests++;
    if (rdy_cnt != 0) begin n_fail++; $display("FAIL reset_no_ready: %0d ready pulses, need 0", rdy_cnt); end
    n_tests++;
    if ({bus.if_data_o, bus.mem_rdata_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid_data: got %h %h, need 0", bus.if_data_o, bus.mem_rdata_o);
    end
    rst = 1'b1;
    exp_if_data = 32'h0;
    exp_mem_rdata = 32'h0;
  endtask

  // Both requesters held from a fresh reset; the fair instance should alternate, the strict one not.
  task automatic test_fair();
    bit order[$]; bit exp_order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int both = 0; int s_mem = 0; int s_if = 0; int bad_data = 0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_size_i = 2'd2; bus.mem_addr_i = 32'h200;
    s_bus.if_req_i = 1'b1; s_bus.if_addr_i = 32'h100;
    s_bus.mem_req_i = 1'b1; s_bus.mem_we_i = 1'b0; s_bus.mem_size_i = 2'd2; s_bus.mem_addr_i = 32'h200;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      @(negedge clk);
      if (bus.if_ready_o && bus.mem_ready_o) both++;
      if (bus.mem_ready_o) begin
        order.push_back(1'b1);
        if (bus.mem_rdata_o !== model_read(32'h200, 4)) bad_data++;
      end else if (bus.if_ready_o) begin
        order.push_back(1'b0);
        if (bus.if_data_o !== model_read(32'h100, 4)) bad_data++;
      end
      if (s_bus.mem_ready_o) s_mem++;
      if (s_bus.if_ready_o) s_if++;
    end
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
    s_bus.if_req_i = 1'b0; s_bus.mem_req_i = 1'b0;
    n_tests++;
    if (order.size() != 4) begin n_fail++; $display("FAIL fair_count: got %0d grants, need 4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i < order.size() && order[i] !== exp_order[i]) begin
        n_fail++; $display("FAIL fair_order[%0d]: got %s, need %s", i,
                           order[i] ? "MEM" : "IF", exp_order[i] ? "MEM" : "IF");
      end
    end
    n_tests++;
    if (both != 0 || bad_data != 0) begin
      n_fail++; $display("FAIL fair_pulses: both-ready=%0d bad-data=%0d, need 0/0", both, bad_data);
    end
    n_tests++;
    if (s_if != 0 || s_mem < 3) begin
      n_fail++; $display("FAIL strict_priority: got mem=%0d if=%0d, need mem>=3 if=0", s_mem, s_if);
    end
    exp_if_data = model_read(32'h100, 4);
    exp_mem_rdata = model_read(32'h200, 4);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] d; bit oth;
    for (int i = 0; i < 256; i++) poke(32'h1000 + 32'(i), 8'($urandom));
    for (int it = 0; it < 40; it++) begin
      int op = $urandom_range(0, 2);
      logic [1:0] size = 2'($urandom_range(0, 3));
      logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                    : 32'h1000 + 32'($urandom_range(0, 250));
      logic [31:0] w = $urandom;
      logic [31:0] exp_d;
      int n = (op == 0) ? 4 : nbytes(size);
      int exp_lat = (op == 2) ? n + 1 : n + 2;
      int we_cnt = 0;
      if (op == 0) exp_d = model_read(a, 4);
      else if (op == 1) exp_d = model_read(a, n);
      else exp_d = exp_mem_rdata;
      txn(op == 0, op == 2, size, a, w, lat, d, oth);
      if (op == 2) model_write(a, n, w);
      if (op == 0) exp_if_data = exp_d;
      if (op == 1) exp_mem_rdata = exp_d;
      foreach (tr_we[j]) if (tr_we[j]) we_cnt++;
      n_tests++;
      if (lat != exp_lat || d !== exp_d || oth || we_cnt != ((op == 2) ? n : 0)) begin
        n_fail++; $display("FAIL random[%0d] op=%0d size=%0d addr=%h: got lat=%0d data=%h other=%b we=%0d, need lat=%0d data=%h other=0 we=%0d",
                           it, op, size, a, lat, d, oth, we_cnt, exp_lat, exp_d, (op == 2) ? n : 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.flush_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_size_i = 2'd0;
    bus.mem_addr_i = 32'h0; bus.mem_wdata_i = 32'h0;
    s_bus.if_req_i = 1'b0; s_bus.if_addr_i = 32'h0; s_bus.flush_i = 1'b0;
    s_bus.mem_req_i = 1'b0; s_bus.mem_we_i = 1'b0; s_bus.mem_size_i = 2'd0;
    s_bus.mem_addr_i = 32'h0; s_bus.mem_wdata_i = 32'h0; s_bus.ram_din_i = 8'h0;
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_flush();
    test_wrap();
    test_reset_mid_write();
    test_fair();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
